// File: rtl/ir_sched_pkg.sv
// ---------------------------------------------------------------------------
// ir_sched_pkg
//   Shared types and helpers for the IR line-sensor scheduler.
//   - state_t        : scheduler FSM state encoding
//   - NUM_CH         : number of IR sensor channels
//   - W_SHIFT_TAB    : per-step weight magnitude as a left-shift amount
//   - W_NEG_TAB      : per-step weight sign (1 = subtract)
//   - weighted_term  : res scaled by the step weight, as a 17-bit signed term
//   - sat16          : clip a 17-bit signed accumulator into 16 bits
// ---------------------------------------------------------------------------
package ir_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_START  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 17;

    // Weights {+1,-1,+2,-2,+4,-4,+8,-8}: magnitude is 1 << shift, two bits per step.
    localparam logic [15:0] W_SHIFT_TAB = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};
    // Odd steps carry the negative weight.
    localparam logic [7:0]  W_NEG_TAB   = 8'b1010_1010;

    // res * W[step] built from a shift and an optional negate (no multiplier).
    function automatic logic signed [16:0] weighted_term(input logic [2:0]  step,
                                                         input logic [11:0] res);
        logic [1:0]          sh;
        logic [16:0]         mag;
        logic signed [16:0]  term;
        sh  = W_SHIFT_TAB[{step, 1'b0} +: 2];
        mag = {5'd0, res} << sh;
        if (W_NEG_TAB[step]) begin
            term = -$signed(mag);
        end else begin
            term = $signed(mag);
        end
        return term;
    endfunction

    // Saturate the 17-bit accumulator to the signed 16-bit error range.
    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        logic [15:0] r;
        if (v > 17'sd32767) begin
            r = 16'h7FFF;
        end else if (v < -17'sd32768) begin
            r = 16'h8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/ir_frame_timer.sv
// ---------------------------------------------------------------------------
// ir_frame_timer
//   Shared down-counter used for the settle delay, the inter-frame gap and
//   the conversion timeout. A start pulse loads the count; 'expired' is high
//   in the last cycle of the programmed interval (the N-th cycle after start).
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     start       : load load_val and begin counting (wins over stop)
//     stop        : abandon the current interval
//     scale       : apply FAST_SIM divide-by-16 to this load
//     load_val    : interval length in cycles (17 bits)
//     expired     : interval has elapsed (valid while running)
// ---------------------------------------------------------------------------
module ir_frame_timer
    import ir_sched_pkg::*;
#(
    parameter int FAST_SIM = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             scale,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic [CNT_W-1:0] scaled_s;
    logic [CNT_W-1:0] eff_s;

    // Effective interval: optional sim speed-up, never shorter than one cycle.
    always_comb begin
        scaled_s = load_val;
        eff_s    = load_val;
        if (scale && (FAST_SIM != 0)) begin
            scaled_s = load_val >> 4;
        end else begin
            scaled_s = load_val;
        end
        if (scaled_s == 17'd0) begin
            eff_s = 17'd1;
        end else begin
            eff_s = scaled_s;
        end
    end

    assign expired = run_r && (cnt_r == 17'd0);

    // Down-counter; stops itself once the interval has expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 17'd0;
            run_r <= 1'b0;
        end else if (start) begin
            cnt_r <= eff_s - 17'd1;
            run_r <= 1'b1;
        end else if (stop || expired) begin
            cnt_r <= 17'd0;
            run_r <= 1'b0;
        end else if (run_r) begin
            cnt_r <= cnt_r - 17'd1;
        end
    end

endmodule

// File: rtl/ir_err_sched.sv
// ---------------------------------------------------------------------------
// ir_err_sched
//   Schedules the shared A2D across the 8 IR line sensors once per frame and
//   produces a signed, weighted steering error for the PID loop.
//   Frame: IR emitters on -> settle -> 8 conversions -> publish -> emitters
//   off for the inter-frame gap -> repeat. go low parks the block in IDLE.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     go            : enable scheduling
//     cnv_cmplt,res : A2D completion pulse and 12-bit unsigned result
//     strt_cnv      : 1-cycle conversion start, chnnl selects the channel
//     IR_en         : IR emitter enable
//     error         : saturated signed weighted error, held between frames
//     err_vld       : 1-cycle pulse when error/line_present update
//     line_present  : raw sum of all channels above LINE_THRES
//     to_err        : sticky conversion-timeout flag, cleared by a good frame
// ---------------------------------------------------------------------------
module ir_err_sched
    import ir_sched_pkg::*;
#(
    parameter int          FAST_SIM   = 0,
    parameter int          SETTLE_CYC = 4096,
    parameter int          FRAME_CYC  = 65536,
    parameter int          TIMEOUT    = 1024,
    parameter logic [14:0] LINE_THRES = 15'h0400
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        go,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    output logic        IR_en,
    output logic [15:0] error,
    output logic        err_vld,
    output logic        line_present,
    output logic        to_err
);

    localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] FRAME_LD   = CNT_W'(FRAME_CYC);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(TIMEOUT);

    state_t             state_r;
    logic [2:0]         step_r;
    logic signed [16:0] acc_r;
    logic [14:0]        raw_r;

    logic signed [16:0] acc_nx_s;
    logic [14:0]        raw_nx_s;
    logic               tmr_start_s;
    logic               tmr_stop_s;
    logic               tmr_scale_s;
    logic [CNT_W-1:0]   tmr_load_s;
    logic               tmr_exp_s;

    // Running sums including the sample arriving this cycle.
    always_comb begin
        acc_nx_s = acc_r + weighted_term(step_r, res);
        raw_nx_s = raw_r + {3'd0, res};
    end

    // Timer load requests, aligned with the FSM transitions that enter
    // SETTLE, WAIT and GAP. Settle/gap lengths are subject to FAST_SIM.
    always_comb begin
        tmr_start_s = 1'b0;
        tmr_stop_s  = !go;
        tmr_scale_s = 1'b0;
        tmr_load_s  = 17'd0;
        if (go) begin
            case (state_r)
                ST_IDLE: begin
                    tmr_start_s = 1'b1;
                    tmr_scale_s = 1'b1;
                    tmr_load_s  = SETTLE_LD;
                end
                ST_START: begin
                    tmr_start_s = 1'b1;
                    tmr_scale_s = 1'b0;
                    tmr_load_s  = TIMEOUT_LD;
                end
                ST_WAIT: begin
                    if (!cnv_cmplt && tmr_exp_s) begin
                        tmr_start_s = 1'b1;
                        tmr_scale_s = 1'b1;
                        tmr_load_s  = FRAME_LD;
                    end else begin
                        tmr_start_s = 1'b0;
                    end
                end
                ST_DONE: begin
                    tmr_start_s = 1'b1;
                    tmr_scale_s = 1'b1;
                    tmr_load_s  = FRAME_LD;
                end
                ST_GAP: begin
                    if (tmr_exp_s) begin
                        tmr_start_s = 1'b1;
                        tmr_scale_s = 1'b1;
                        tmr_load_s  = SETTLE_LD;
                    end else begin
                        tmr_start_s = 1'b0;
                    end
                end
                default: begin
                    tmr_start_s = 1'b0;
                end
            endcase
        end else begin
            tmr_start_s = 1'b0;
        end
    end

    ir_frame_timer #(
        .FAST_SIM (FAST_SIM)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (tmr_start_s),
        .stop     (tmr_stop_s),
        .scale    (tmr_scale_s),
        .load_val (tmr_load_s),
        .expired  (tmr_exp_s)
    );

    // Frame FSM with registered outputs; go low overrides every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            step_r       <= 3'd0;
            acc_r        <= 17'sd0;
            raw_r        <= 15'd0;
            strt_cnv     <= 1'b0;
            chnnl        <= 3'd0;
            IR_en        <= 1'b0;
            error        <= 16'h0000;
            err_vld      <= 1'b0;
            line_present <= 1'b0;
            to_err       <= 1'b0;
        end else if (!go) begin
            // Partial frame is dropped; published results are kept.
            state_r  <= ST_IDLE;
            strt_cnv <= 1'b0;
            IR_en    <= 1'b0;
            err_vld  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r  <= ST_SETTLE;
                    IR_en    <= 1'b1;
                    strt_cnv <= 1'b0;
                    err_vld  <= 1'b0;
                end
                ST_SETTLE: begin
                    if (tmr_exp_s) begin
                        state_r  <= ST_START;
                        step_r   <= 3'd0;
                        acc_r    <= 17'sd0;
                        raw_r    <= 15'd0;
                        chnnl    <= 3'd0;
                        strt_cnv <= 1'b1;
                    end
                end
                ST_START: begin
                    strt_cnv <= 1'b0;
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A completion in the expiry cycle still counts.
                    if (cnv_cmplt) begin
                        acc_r <= acc_nx_s;
                        raw_r <= raw_nx_s;
                        if (step_r == 3'd7) begin
                            error        <= sat16(acc_nx_s);
                            line_present <= (raw_nx_s > LINE_THRES);
                            err_vld      <= 1'b1;
                            to_err       <= 1'b0;
                            state_r      <= ST_DONE;
                        end else begin
                            step_r   <= step_r + 3'd1;
                            chnnl    <= step_r + 3'd1;
                            strt_cnv <= 1'b1;
                            state_r  <= ST_START;
                        end
                    end else if (tmr_exp_s) begin
                        to_err  <= 1'b1;
                        IR_en   <= 1'b0;
                        state_r <= ST_GAP;
                    end
                end
                ST_DONE: begin
                    err_vld <= 1'b0;
                    IR_en   <= 1'b0;
                    state_r <= ST_GAP;
                end
                ST_GAP: begin
                    if (tmr_exp_s) begin
                        IR_en   <= 1'b1;
                        state_r <= ST_SETTLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    IR_en    <= 1'b0;
                    strt_cnv <= 1'b0;
                    err_vld  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ir_err_sched.sv
// ---------------------------------------------------------------------------
// tb_ir_err_sched
//   Self-checking bench for ir_err_sched. An A2D responder answers each
//   strt_cnv after a random latency with a per-channel result; a frame-level
//   model recomputes the weighted, saturated error and line_present from the
//   values actually returned.
// ---------------------------------------------------------------------------
module tb_ir_err_sched;

    localparam int SETTLE_P   = 1024;
    localparam int FRAME_P    = 2048;
    localparam int TIMEOUT_P  = 100;
    localparam int SETTLE_EFF = SETTLE_P / 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        go;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        IR_en;
    logic [15:0] error;
    logic        err_vld;
    logic        line_present;
    logic        to_err;

    int checks = 0;
    int errors = 0;

    logic [11:0] res_tab [8];
    int          withhold_ch = -1;
    logic [2:0]  sent_ch  [$];
    logic [11:0] sent_res [$];
    logic [15:0] prev_error = 16'h0000;
    logic        prev_lp    = 1'b0;

    always #5 clk = ~clk;

    ir_err_sched #(
        .FAST_SIM   (1),
        .SETTLE_CYC (SETTLE_P),
        .FRAME_CYC  (FRAME_P),
        .TIMEOUT    (TIMEOUT_P),
        .LINE_THRES (15'h0400)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .go           (go),
        .cnv_cmplt    (cnv_cmplt),
        .res          (res),
        .strt_cnv     (strt_cnv),
        .chnnl        (chnnl),
        .IR_en        (IR_en),
        .error        (error),
        .err_vld      (err_vld),
        .line_present (line_present),
        .to_err       (to_err)
    );

    // A2D responder: answers every strt_cnv after 3..8 cycles unless withheld.
    initial begin
        logic [2:0] ch;
        int         d;
        cnv_cmplt = 1'b0;
        res       = 12'h000;
        forever begin
            @(posedge clk);
            #1;
            while (strt_cnv === 1'b1) begin
                ch = chnnl;
                d  = $urandom_range(3, 8);
                repeat (d) @(posedge clk);
                #1;
                if (int'(ch) != withhold_ch) begin
                    if (go === 1'b1) begin
                        checks++;
                        if (chnnl !== ch) begin
                            errors++;
                            $display("FAIL chnnl_stable: got %0d want %0d", chnnl, ch);
                        end
                    end
                    cnv_cmplt = 1'b1;
                    res       = res_tab[ch];
                    sent_ch.push_back(ch);
                    sent_res.push_back(res_tab[ch]);
                    @(posedge clk);
                    #1;
                    cnv_cmplt = 1'b0;
                    res       = 12'($urandom_range(0, 4095));
                end
            end
        end
    end

    // Frame model: sum of W[ch]*res, clipped to 16 bits; line if raw > 0x400.
    function automatic void model_frame(output logic [15:0] e, output logic lp);
        int w [8] = '{1, -1, 2, -2, 4, -4, 8, -8};
        int sum = 0;
        int raw = 0;
        for (int i = 0; i < sent_ch.size(); i++) begin
            sum += w[sent_ch[i]] * int'(sent_res[i]);
            raw += int'(sent_res[i]);
        end
        if (sum > 32767) e = 16'h7FFF;
        else if (sum < -32768) e = 16'h8000;
        else e = 16'(sum);
        lp = (raw > 1024);
    endfunction

    task automatic clear_sent();
        sent_ch.delete();
        sent_res.delete();
    endtask

    // Waits for one complete frame (starting with IR_en low) and checks it.
    task automatic wait_frame(input string name);
        int         n = 0;
        int         settle = 0;
        bit         seen_strt = 1'b0;
        bit         done = 1'b0;
        logic [2:0] order [$];
        logic [15:0] exp_e;
        logic        exp_lp;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
            if (strt_cnv === 1'b1) begin
                order.push_back(chnnl);
                seen_strt = 1'b1;
            end else if (IR_en === 1'b1 && !seen_strt) begin
                settle++;
            end
            if (err_vld === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_err_vld_timeout: no err_vld within %0d cycles", name, n);
        end else begin
            model_frame(exp_e, exp_lp);
            checks++;
            if (error !== exp_e) begin
                errors++;
                $display("FAIL %s_error: got %h want %h", name, error, exp_e);
            end
            checks++;
            if (line_present !== exp_lp) begin
                errors++;
                $display("FAIL %s_line_present: got %b want %b", name, line_present, exp_lp);
            end
            checks++;
            if (to_err !== 1'b0) begin
                errors++;
                $display("FAIL %s_to_err: got %b want 0", name, to_err);
            end
            checks++;
            if (settle != SETTLE_EFF) begin
                errors++;
                $display("FAIL %s_settle: got %0d cycles want %0d", name, settle, SETTLE_EFF);
            end
            checks++;
            if (order.size() != 8 || sent_ch.size() != 8) begin
                errors++;
                $display("FAIL %s_conversions: got %0d starts %0d results want 8",
                         name, order.size(), sent_ch.size());
            end else begin
                for (int i = 0; i < 8; i++) begin
                    if (order[i] !== 3'(i)) begin
                        errors++;
                        $display("FAIL %s_chnnl_walk: step %0d got %0d", name, i, order[i]);
                    end
                end
            end
            @(negedge clk);
            checks++;
            if (err_vld !== 1'b0) begin
                errors++;
                $display("FAIL %s_err_vld_width: got %b want 0", name, err_vld);
            end
            prev_error = exp_e;
            prev_lp    = exp_lp;
        end
    endtask

    task automatic test_reset();
        int bad_ir = 0;
        int bad_st = 0;
        int bad_vld = 0;
        rst_n = 1'b0;
        go    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({IR_en, strt_cnv, chnnl, error, err_vld, line_present, to_err} !== 24'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0",
                     {IR_en, strt_cnv, chnnl, error, err_vld, line_present, to_err});
        end
        rst_n = 1'b1;
        repeat (1000) begin
            @(negedge clk);
            if (IR_en !== 1'b0) bad_ir++;
            if (strt_cnv !== 1'b0) bad_st++;
            if (err_vld !== 1'b0) bad_vld++;
        end
        checks++;
        if (bad_ir != 0) begin errors++; $display("FAIL idle_IR_en: %0d cycles high want 0", bad_ir); end
        checks++;
        if (bad_st != 0) begin errors++; $display("FAIL idle_strt_cnv: %0d pulses want 0", bad_st); end
        checks++;
        if (bad_vld != 0) begin errors++; $display("FAIL idle_err_vld: %0d pulses want 0", bad_vld); end
        checks++;
        if (error !== 16'h0000) begin errors++; $display("FAIL idle_error: got %h want 0000", error); end
    endtask

    task automatic test_flat();
        for (int i = 0; i < 8; i++) res_tab[i] = 12'h100;
        clear_sent();
        go = 1'b1;
        for (int f = 0; f < 2; f++) begin
            wait_frame("flat");
            checks++;
            if (error !== 16'h0000 || line_present !== 1'b1) begin
                errors++;
                $display("FAIL flat_const: got %h/%b want 0000/1", error, line_present);
            end
            clear_sent();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) res_tab[i] = (i % 2 == 0) ? 12'hFFF : 12'h000;
        clear_sent();
        wait_frame("sat_pos");
        checks++;
        if (error !== 16'h7FFF || line_present !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos_const: got %h/%b want 7fff/1", error, line_present);
        end
        for (int i = 0; i < 8; i++) res_tab[i] = (i % 2 == 1) ? 12'hFFF : 12'h000;
        clear_sent();
        wait_frame("sat_neg");
        checks++;
        if (error !== 16'h8000) begin
            errors++;
            $display("FAIL sat_neg_const: got %h want 8000", error);
        end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < 8; i++) res_tab[i] = 12'd128;
        clear_sent();
        wait_frame("thres_eq");
        res_tab[0] = 12'd129;
        clear_sent();
        wait_frame("thres_above");
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 100));
        clear_sent();
        wait_frame("low_line");
    endtask

    task automatic test_random();
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
            clear_sent();
            wait_frame("random");
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int n3 = -1;
        int vld = 0;
        bit hit = 1'b0;
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
        withhold_ch = 3;
        clear_sent();
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            if (strt_cnv === 1'b1 && chnnl === 3'd3) n3 = n;
            if (err_vld === 1'b1) vld++;
            if (to_err === 1'b1) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL timeout_to_err: not set within %0d cycles", n);
        end else begin
            checks++;
            if (n3 < 0 || (n - n3) < TIMEOUT_P || (n - n3) > TIMEOUT_P + 2) begin
                errors++;
                $display("FAIL timeout_latency: got %0d cycles want %0d..%0d",
                         n - n3, TIMEOUT_P, TIMEOUT_P + 2);
            end
            checks++;
            if (IR_en !== 1'b0) begin errors++; $display("FAIL timeout_IR_en: got %b want 0", IR_en); end
        end
        checks++;
        if (vld != 0) begin errors++; $display("FAIL timeout_err_vld: %0d pulses want 0", vld); end
        checks++;
        if (error !== prev_error || line_present !== prev_lp) begin
            errors++;
            $display("FAIL timeout_hold: got %h/%b want %h/%b", error, line_present, prev_error, prev_lp);
        end
        withhold_ch = -1;
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
        clear_sent();
        wait_frame("after_timeout");
    endtask

    task automatic test_go_drop();
        int n = 0;
        bit hit = 1'b0;
        int bad = 0;
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
        clear_sent();
        while (!hit && n < 3000) begin
            @(negedge clk);
            n++;
            if (strt_cnv === 1'b1 && chnnl === 3'd5) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL go_drop_step5: step 5 not reached in %0d cycles", n);
        end
        @(posedge clk);
        #1;
        go = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (IR_en !== 1'b0 || strt_cnv !== 1'b0) begin
            errors++;
            $display("FAIL go_drop_outputs: IR_en=%b strt_cnv=%b want 0/0", IR_en, strt_cnv);
        end
        repeat (40) begin
            @(negedge clk);
            if (IR_en !== 1'b0 || strt_cnv !== 1'b0 || err_vld !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL go_low_quiet: %0d active cycles want 0", bad); end
        checks++;
        if (error !== prev_error || line_present !== prev_lp) begin
            errors++;
            $display("FAIL go_drop_hold: got %h/%b want %h/%b", error, line_present, prev_error, prev_lp);
        end
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
        clear_sent();
        go = 1'b1;
        wait_frame("go_restart");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int bad = 0;
        while (!(strt_cnv === 1'b1 && chnnl === 3'd2) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({IR_en, strt_cnv, chnnl, error, err_vld, line_present, to_err} !== 24'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %h want 0",
                     {IR_en, strt_cnv, chnnl, error, err_vld, line_present, to_err});
        end
        go = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (IR_en !== 1'b0 || strt_cnv !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_release_idle: %0d active cycles want 0", bad); end
        for (int i = 0; i < 8; i++) res_tab[i] = 12'($urandom_range(0, 4095));
        clear_sent();
        go = 1'b1;
        wait_frame("after_reset");
    endtask

    initial begin
        for (int i = 0; i < 8; i++) res_tab[i] = 12'h000;
        test_reset();
        test_flat();
        test_saturation();
        test_threshold();
        test_random();
        test_timeout();
        test_go_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global bound so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
